// File: rtl/wb_pkg.sv
// Shared definitions for the writeback select unit.
// Holds the skid-buffer state encoding and the source indices used by control.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_TWO   = 2'd2
  } wb_state_e;

  // Source indices as the control unit names them.
  localparam int unsigned SRC_ALU   = 0;
  localparam int unsigned SRC_MDR   = 1;
  localparam int unsigned SRC_HI    = 2;
  localparam int unsigned SRC_LO    = 3;
  localparam int unsigned SRC_SHIFT = 4;
  localparam int unsigned SRC_LOAD  = 5;
  localparam int unsigned SRC_SLT   = 6;
  localparam int unsigned SRC_CONST = 7;

endpackage

// File: rtl/wb_select_unit_if.sv
// Handshake bus of the writeback select unit.
// Input side : in_valid/in_ready, sel, src_data (flattened sources), in_dest.
// Output side: out_valid/out_ready, out_data, out_dest.
// master = producer/consumer environment, slave = the select unit.
interface wb_select_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned DEST_W = 5
);
  localparam int unsigned SEL_W = $clog2(N_SRC);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [DEST_W-1:0]       in_dest;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [DEST_W-1:0]       out_dest;

  modport master (
    output in_valid, sel, src_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data, out_dest
  );

  modport slave (
    input  in_valid, sel, src_data, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_dest
  );
endinterface

// File: rtl/wb_src_mux.sv
// Combinational N_SRC:1 writeback source select.
// Ports: sel (source index), src_data (flattened sources, source k at
// [k*DATA_W +: DATA_W]), data_c (selected source, zero when sel is out of
// range), err_c (sel does not name an existing source).
module wb_src_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_SRC  = 8
) (
  input  logic [$clog2(N_SRC)-1:0] sel,
  input  logic [N_SRC*DATA_W-1:0]  src_data,
  output logic [DATA_W-1:0]        data_c,
  output logic                     err_c
);
  localparam int unsigned SEL_W = $clog2(N_SRC);

  // Match sel against every real source; no hit means out of range.
  always_comb begin
    data_c = '0;
    err_c  = 1'b1;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        data_c = src_data[k*DATA_W +: DATA_W];
        err_c  = 1'b0;
      end
    end
  end
endmodule

// File: rtl/wb_select_unit.sv
// Registered writeback source select with a 2-entry skid buffer.
// Ports: clk, reset (async, active-low), flush (sync clear of buffered
// results), bus (slave side of wb_select_unit_if), sel_err (sticky
// out-of-range select flag), wb_count (completed writebacks, wrapping).
// Interface parameters must match DATA_W/N_SRC/DEST_W given here.
module wb_select_unit
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned DEST_W      = 5,
  parameter int unsigned SUPPRESS_R0 = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  wb_select_unit_if.slave   bus,
  output logic              sel_err,
  output logic [CNT_W-1:0]  wb_count
);

  wb_state_e         state;
  logic [DATA_W-1:0] m_data;
  logic [DEST_W-1:0] m_dest;
  logic [DATA_W-1:0] s_data;
  logic [DEST_W-1:0] s_dest;
  logic              out_valid_q;
  logic              in_ready_q;

  logic [DATA_W-1:0] mux_data_c;
  logic              mux_err_c;
  logic              accept_c;
  logic              complete_c;
  logic              drop_c;
  logic              enq_c;

  wb_src_mux #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC)
  ) u_src_mux (
    .sel      (bus.sel),
    .src_data (bus.src_data),
    .data_c   (mux_data_c),
    .err_c    (mux_err_c)
  );

  // Handshake qualifiers; a flush discards whatever is offered alongside it.
  assign accept_c   = bus.in_valid && in_ready_q;
  assign complete_c = out_valid_q && bus.out_ready;
  assign drop_c     = (SUPPRESS_R0 != 0) && (bus.in_dest == '0);
  assign enq_c      = accept_c && !flush && !drop_c;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = m_data;
  assign bus.out_dest  = m_dest;

  // Buffer FSM, skid registers, sticky error and completion counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WB_EMPTY;
      m_data      <= '0;
      m_dest      <= '0;
      s_data      <= '0;
      s_dest      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      sel_err     <= 1'b0;
      wb_count    <= '0;
    end else begin
      // A completion in a flush cycle still happened on the bus.
      if (complete_c) begin
        wb_count <= wb_count + CNT_W'(1);
      end
      // Suppressed r0 writes still report a bad select.
      if (accept_c && !flush && mux_err_c) begin
        sel_err <= 1'b1;
      end

      if (flush) begin
        state       <= WB_EMPTY;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        case (state)
          WB_EMPTY: begin
            in_ready_q <= 1'b1;
            if (enq_c) begin
              m_data      <= mux_data_c;
              m_dest      <= bus.in_dest;
              out_valid_q <= 1'b1;
              state       <= WB_ONE;
            end
          end
          WB_ONE: begin
            if (enq_c && complete_c) begin
              m_data <= mux_data_c;
              m_dest <= bus.in_dest;
            end else if (enq_c) begin
              // Consumer stalled: park the new result in the skid slot.
              s_data     <= mux_data_c;
              s_dest     <= bus.in_dest;
              in_ready_q <= 1'b0;
              state      <= WB_TWO;
            end else if (complete_c) begin
              out_valid_q <= 1'b0;
              state       <= WB_EMPTY;
            end
          end
          WB_TWO: begin
            if (complete_c) begin
              m_data     <= s_data;
              m_dest     <= s_dest;
              in_ready_q <= 1'b1;
              state      <= WB_ONE;
            end
          end
          default: begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= WB_EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/wb_select_unit.md
Name: wb_select_unit

Overview:
- Parametrised, registered successor to the writeback-source select mux.
- Selects one of N_SRC data sources for the register-file write port, then buffers the result with a valid/ready handshake.
- A 2-entry skid buffer lets the control FSM stall writeback without losing a result.
- Adds out-of-range select detection, optional $zero-write suppression, flush, and a committed-writeback counter.

Parameters:
- DATA_W, 32, width of each source and of the result
- N_SRC, 8, number of selectable sources, 2..16
- SEL_W, $clog2(N_SRC), select width; derived, never overridden
- DEST_W, 5, destination register index width
- SUPPRESS_R0, 1, when 1 a transaction with dest 0 is accepted and dropped without producing output
- CNT_W, 16, width of the committed-writeback counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all buffered transactions
- in_valid  in  1  source selection and data are valid this cycle
- in_ready  out  1  unit can accept a transaction
- sel  in  SEL_W  source index
- src_data  in  N_SRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W]
- in_dest  in  DEST_W  destination register index
- out_valid  out  1  out_data/out_dest hold a valid writeback
- out_ready  in  1  register file accepts the writeback
- out_data  out  DATA_W  selected result
- out_dest  out  DEST_W  destination register index
- sel_err  out  1  sticky flag: an out-of-range sel was accepted
- wb_count  out  CNT_W  number of writebacks completed

Behaviour:
- Reset (reset=0, asynchronous):
  - Buffer goes to EMPTY.
  - out_valid=0, out_data=0, out_dest=0, sel_err=0, wb_count=0.
  - in_ready=1 one clock after reset is released.
- Handshakes:
  - Input accepted when in_valid&&in_ready.
  - Output completes when out_valid&&out_ready.
  - Inputs are sampled only on acceptance; src_data may change freely otherwise.
- Selection, evaluated at acceptance:
  - data = src_data[sel] when sel<N_SRC.
  - Otherwise data=0 and sel_err is set. sel_err stays set until reset; flush does not clear it.
- Suppression: with SUPPRESS_R0=1 and in_dest=0, the transaction is accepted (in_ready rules unchanged) but never enqueued. It does not count toward wb_count, and sel_err is still evaluated.
- Buffer FSM (main register M, skid register S):
  - EMPTY:
    - out_valid=0, in_ready=1.
    - Accept → M loaded → ONE.
  - ONE:
    - out_valid=1, in_ready=1.
    - Accept and complete in the same cycle → M reloaded → ONE.
    - Accept only → S loaded → TWO.
    - Complete only → EMPTY.
  - TWO:
    - out_valid=1, in_ready=0.
    - Complete → M←S → ONE.
- Latency:
  - 1 cycle from acceptance to out_valid when empty.
  - Full throughput of 1/cycle when out_ready is held high.
- Ordering: strictly FIFO; no reordering.
- Output stability: out_data and out_dest stay stable while out_valid=1 and out_ready=0.
- Flush:
  - Next state is EMPTY; out_valid=0 the following cycle.
  - A transaction offered in the flush cycle is discarded and does not count.
  - A completion in the flush cycle is still counted.
  - flush has priority over accept.
- wb_count increments by 1 per completion and wraps modulo 2^CNT_W.
- Reset mid-transfer: all buffered data is lost; no partial output.

Decomposition:
- Shared package wb_pkg holds:
  - the buffer state encoding (WB_EMPTY=2'd0, WB_ONE=2'd1, WB_TWO=2'd2)
  - the named source indices used by the control unit: SRC_ALU=0, SRC_MDR=1, SRC_HI=2, SRC_LO=3, SRC_SHIFT=4, SRC_LOAD=5, SRC_SLT=6, SRC_CONST=7
- One sub-module is natural: wb_src_mux, a combinational N_SRC:1 select with an out-of-range zero output and an error bit.
- Buffer, FSM and counter stay in the top module.

Test Plan:
- Reset then single transfer: hold out_ready=1; in sel=2, src k = 32'h1000_0000+k, in_dest=9 → next cycle out_valid=1, out_data=32'h1000_0002, out_dest=9; wb_count=1.
- Backpressure/skid: with out_ready=0, accept sel=0 (dest 3), then sel=5 (dest 4) → in_ready=0 in TWO. Raise out_ready → outputs dest 3 then dest 4 in order, with data held stable during the stall.
- Out-of-range: N_SRC=6, sel=7, dest 8 → out_data=0, sel_err=1. After 10 further valid transfers sel_err is still 1. flush leaves it set; reset clears it.
- Zero-register suppression: SUPPRESS_R0=1, dest 0 with sel 1 → in_ready=1, no out_valid, wb_count unchanged. With SUPPRESS_R0=0 → output appears with out_dest=0.
- Flush in TWO with simultaneous in_valid=1 and out_ready=1 → next cycle out_valid=0, state EMPTY, wb_count incremented by exactly 1, offered transaction never appears.
- Counter wrap: CNT_W=4, stream 17 transfers at full rate → wb_count=1; throughput is 1 per cycle with no bubbles.
